instr_mem_loader: RTL

Parametrised instruction memory with an in-system programming port and a handshaked fetch port. It sits between the fetch stage and an external loader. A program is streamed in word by word through a start/valid/ready handshake. The processor then fetches from it with one-cycle registered latency. Contents are never hardcoded and survive reset; only control state is reset.

---
 rtl/instr_mem_loader.sv | 108 ++++++++++
 1 files changed

// File: rtl/instr_mem_loader.sv
// Instruction memory that can be reprogrammed in-system through a start/valid/ready stream.
// Fetches have one-cycle registered latency. Memory contents survive reset; control state does not.
module instr_mem_loader #(
  parameter int DATA_W = 9,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_err,
  output logic              fetch_busy,
  input  logic              prog_start,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_last,
  output logic              prog_ready,
  output logic              prog_done,
  output logic [ADDR_W:0]   prog_count
);

  // state | meaning
  // RUN   | fetch port live, waiting for prog_start
  // PROG  | accepting program words, fetches refused
  // DONE  | one-cycle session-end pulse, fetches still refused
  typedef enum logic [1:0] {RUN, PROG, DONE} state_t;

  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  ptr, ptr_nxt;
  logic [ADDR_W:0]   count_nxt;
  logic              wr_en;
  logic              fetch_acc;
  logic              addr_ok;
  logic [DATA_W-1:0] mem [DEPTH];

  assign addr_ok = ({1'b0, fetch_addr} < DEPTH_C);

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    count_nxt  = prog_count;
    wr_en      = 1'b0;
    fetch_acc  = 1'b0;
    prog_ready = 1'b0;
    prog_done  = 1'b0;
    fetch_busy = 1'b1;
    case (state)
      RUN: begin
        fetch_busy = 1'b0;
        // a session start wins over a fetch in the same cycle
        if (prog_start) begin
          state_nxt = PROG;
          ptr_nxt   = '0;
          count_nxt = '0;
        end else begin
          fetch_acc = fetch_req;
        end
      end
      PROG: begin
        prog_ready = 1'b1;
        if (prog_valid) begin
          wr_en     = 1'b1;
          ptr_nxt   = ptr + IDX_W'(1);
          count_nxt = prog_count + (ADDR_W + 1)'(1);
          if (prog_last || ptr == PTR_LAST) state_nxt = DONE;
        end
      end
      DONE: begin
        prog_done = 1'b1;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      ptr         <= '0;
      prog_count  <= '0;
      fetch_valid <= 1'b0;
      fetch_data  <= '0;
      fetch_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      prog_count  <= count_nxt;
      fetch_valid <= fetch_acc;
      if (fetch_acc) begin
        fetch_data <= addr_ok ? mem[fetch_addr[IDX_W-1:0]] : '0;
        fetch_err  <= ~addr_ok;
      end
    end
  end

  // No reset on the array: program contents must outlive rst.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[ptr] <= prog_data;
  end

endmodule
